shift_deser: RTL and testbench
==============================

# shift_deser

Serial-to-parallel receiver paired with `shift_reg2`: it accepts the serial bit stream taken from a `shift_reg2` end bit (`data_out[7]` in left-shift modes, `data_out[0]` in right-shift modes) and rebuilds parallel words. It sits on the receive side of the shifter datapath. It provides a bit counter, a per-word bit-order latch, frame resynchronisation, a one-word output buffer with a valid/ready handshake, and sticky overrun detection.

## Interface
- `WIDTH`, 8: bits per word, ≥2.
- `CNT_W`, $clog2(WIDTH): bit-counter width.
- `clk` in 1: single clock, all state updates on rising edge.
- `reset` in 1: reset is synchronous and active-high.
- `enable` in 1: global qualifier; when low, no bit is accepted and counter/shifter hold. The output handshake still operates.
- `serial_in` in 1: serial data bit.
- `serial_valid` in 1: `serial_in` carries a bit this cycle.
- `frame` in 1: marks the first bit of a word. Discards any partial word.
- `msb_first` in 1: bit order, 1 = MSB first, 0 = LSB first. Latched with the first bit of each word.
- `data_out` out WIDTH: received word, held until accepted.
- `data_valid` out 1: `data_out` holds an unconsumed word.
- `data_ready` in 1: consumer accepts the word when `data_valid & data_ready`.
- `busy` out 1: a partial word is in progress (counter ≠ 0).
- `overrun` out 1: sticky; a completed word was dropped.

## Operation
- Accept condition: `acc = enable & serial_valid`. A cycle without `acc` changes no receive state.
- Internal state:
  - `shreg[WIDTH-1:0]`
  - `cnt[CNT_W-1:0]`
  - `order` (latched bit order)
  - output buffer `data_out` / `data_valid`
- First-bit detection: a bit is a first bit when `acc & (cnt==0 | frame)`. On a first bit, `order <= msb_first` and `cnt <= 1`. With `frame` set, the stale partial word is discarded.
- Bit insertion:
  - MSB-first: `shreg <= {shreg[WIDTH-2:0], serial_in}`.
  - LSB-first: `shreg <= {serial_in, shreg[WIDTH-1:1]}`.
  - On a first bit, the old `shreg` contents are irrelevant; only the WIDTH bits of the current word reach the output.
- Counting: a non-first `acc` increments `cnt`. When an accepted bit is the WIDTH-th bit (`cnt==WIDTH-1`), the word completes and `cnt <= 0`. For WIDTH=8 a first bit is also the final bit only when WIDTH=1, which is disallowed.
- Completion, using the assembled word including the current bit:
  - If the buffer is free (`!data_valid`), or is being drained this cycle (`data_valid & data_ready`), load `data_out` and set `data_valid = 1`.
  - Otherwise drop the word, set `overrun = 1`, and leave `data_out` unchanged.
- Drain: `data_valid & data_ready` with no completion in the same cycle clears `data_valid`. `data_out` holds its last value.
- `frame` without `acc` has no effect.
- `overrun` clears only on `reset`.
- `busy = (cnt != 0)`.
- Reset values: `data_out = 0`, `data_valid = 0`, `busy = 0`, `overrun = 0`, `cnt = 0`, `shreg = 0`, `order = 0`. Reset applied mid-word discards the partial word and clears the buffer, whether or not it has been accepted.

## Timing
- Each bit is sampled on the rising edge where `acc = 1`.
- The WIDTH-th bit's edge loads `data_out` and raises `data_valid`; both are visible in the following cycle. Latency from the last bit to valid output is 1 clock edge.
- Back-to-back words at full rate (`acc` every cycle) are lossless when `data_ready` is held high. The consumer may hold `data_ready` low for up to WIDTH-1 cycles after `data_valid` rises without losing a word.
- `data_out` is stable while `data_valid & !data_ready`.
- `msb_first` is sampled only on first-bit edges. Changing it mid-word has no effect on that word.
- All outputs are registered except `busy`, which is derived from the `cnt` register.

## Test plan
- Reset, then MSB-first bits 1,0,1,0,0,1,0,1 on consecutive cycles with `data_ready = 1` → `data_out = 0xA5` and `data_valid = 1` in the cycle after the 8th bit, for exactly one cycle; `busy` high for cycles 2–8.
- LSB-first with the same bit sequence → `data_out = 0xA5` reversed, i.e. 0xA5 → `0xA5` reads as `8'b10100101` reversed = `0xA5`. Repeat with 1,1,0,0,0,0,0,0 → `0x03`.
- Gaps and enable: insert `serial_valid = 0` and `enable = 0` cycles between bits of 0x3C → same result as a gapless stream; `busy` holds through the gaps.
- Frame resync: send 3 bits, then assert `frame` with a new 8-bit MSB-first word 0xF0 → `data_out = 0xF0`, no spurious word, `overrun = 0`.
- Overrun: hold `data_ready = 0`, send 0x11 then 0x22 → `data_out = 0x11`, `overrun = 1` after the 16th bit. Assert `data_ready` → `data_valid` drops; `overrun` stays 1 until `reset`.
- Simultaneous drain and complete, plus reset mid-word:
  - Raise `data_ready` on the same edge that 0x22 completes → `data_out = 0x22`, `data_valid` stays 1, no overrun.
  - Assert `reset` after 4 bits of a word → all outputs 0; the next 8 bits form a clean word.

Source files
------------

// File: rtl/shift_deser.sv
// Serial-to-parallel receiver for the shift_reg2 end-bit stream. It rebuilds
// WIDTH-bit words and holds each one in a single-entry valid/ready buffer.
module shift_deser #(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             serial_in,
    input  logic             serial_valid,
    input  logic             frame,
    input  logic             msb_first,
    output logic [WIDTH-1:0] data_out,
    output logic             data_valid,
    input  logic             data_ready,
    output logic             busy,
    output logic             overrun
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] ONE_CNT  = CNT_W'(1);

    logic [WIDTH-1:0] shreg_q, shreg_d, shreg_ins;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             order_q, order_d;
    logic [WIDTH-1:0] data_out_q, data_out_d;
    logic             data_valid_q, data_valid_d;
    logic             overrun_q, overrun_d;
    logic             acc, first_bit, last_bit, drain;

    always_comb begin
        acc       = enable & serial_valid;
        // frame forces a word start, so a frame bit can never also close a word
        first_bit = acc & ((cnt_q == '0) | frame);
        last_bit  = acc & ~first_bit & (cnt_q == LAST_CNT);
        drain     = data_valid_q & data_ready;

        order_d   = first_bit ? msb_first : order_q;
        shreg_ins = order_d ? {shreg_q[WIDTH-2:0], serial_in}
                            : {serial_in, shreg_q[WIDTH-1:1]};
        shreg_d   = acc ? shreg_ins : shreg_q;

        cnt_d = cnt_q;
        if (first_bit) begin
            cnt_d = ONE_CNT;
        end else if (last_bit) begin
            cnt_d = '0;
        end else if (acc) begin
            cnt_d = cnt_q + ONE_CNT;
        end

        data_out_d   = data_out_q;
        data_valid_d = data_valid_q;
        overrun_d    = overrun_q;
        if (last_bit) begin
            // a word leaving on this same edge frees the buffer for the new one
            if (!data_valid_q || data_ready) begin
                data_out_d   = shreg_ins;
                data_valid_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end else if (drain) begin
            data_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            shreg_q      <= '0;
            cnt_q        <= '0;
            order_q      <= 1'b0;
            data_out_q   <= '0;
            data_valid_q <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            shreg_q      <= shreg_d;
            cnt_q        <= cnt_d;
            order_q      <= order_d;
            data_out_q   <= data_out_d;
            data_valid_q <= data_valid_d;
            overrun_q    <= overrun_d;
        end
    end

    assign data_out   = data_out_q;
    assign data_valid = data_valid_q;
    assign overrun    = overrun_q;
    assign busy       = (cnt_q != '0);

endmodule

// File: tb/tb_shift_deser.sv
// Self-checking bench for shift_deser: expected words are queued as bits are
// driven and popped when the receiver presents a word.
module tb_shift_deser;

    logic       clk = 1'b0;
    logic       reset;
    logic       enable;
    logic       serial_in;
    logic       serial_valid;
    logic       frame;
    logic       msb_first;
    logic [7:0] data_out;
    logic       data_valid;
    logic       data_ready;
    logic       busy;
    logic       overrun;

    int         n_vec = 0;
    int         n_err = 0;
    logic [7:0] exp_q[$];
    logic [7:0] exp_w;

    shift_deser #(.WIDTH(8)) dut (
        .clk          (clk),
        .reset        (reset),
        .enable       (enable),
        .serial_in    (serial_in),
        .serial_valid (serial_valid),
        .frame        (frame),
        .msb_first    (msb_first),
        .data_out     (data_out),
        .data_valid   (data_valid),
        .data_ready   (data_ready),
        .busy         (busy),
        .overrun      (overrun)
    );

    always #5 clk = ~clk;

    // seq[7] is the first bit on the wire
    function automatic logic [7:0] model_word(input logic [7:0] seq, input bit msb);
        logic [7:0] r;
        if (msb) return seq;
        for (int i = 0; i < 8; i++) r[i] = seq[7-i];
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b, input logic fr);
        serial_in    = b;
        serial_valid = 1'b1;
        enable       = 1'b1;
        frame        = fr;
        tick();
        serial_valid = 1'b0;
        frame        = 1'b0;
    endtask

    // flip_mid toggles msb_first after the first bit; the word must keep its order
    task automatic send_seq(input logic [7:0] seq, input bit msb, input bit push, input bit flip_mid);
        if (push) exp_q.push_back(model_word(seq, msb));
        msb_first = msb;
        for (int i = 7; i >= 0; i--) begin
            send_bit(seq[i], 1'b0);
            if (flip_mid && i == 7) msb_first = ~msb;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        n_vec++; if (data_out !== 8'h00) begin n_err++; $display("FAIL reset_data_out got %h want 00", data_out); end
        n_vec++; if (data_valid !== 1'b0) begin n_err++; $display("FAIL reset_data_valid got %b want 0", data_valid); end
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got %b want 0", busy); end
        n_vec++; if (overrun !== 1'b0) begin n_err++; $display("FAIL reset_overrun got %b want 0", overrun); end
        reset = 1'b0;
        $display("test_reset done");
    endtask

    task automatic test_msb_first();
        logic [7:0] seq;
        seq = 8'b1010_0101;
        data_ready = 1'b1;
        msb_first  = 1'b1;
        exp_q.push_back(model_word(seq, 1'b1));
        for (int i = 7; i >= 0; i--) begin
            send_bit(seq[i], 1'b0);
            if (i > 0) begin
                n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL msb_busy bit%0d got %b want 1", 7 - i, busy); end
                n_vec++; if (data_valid !== 1'b0) begin n_err++; $display("FAIL msb_early_valid bit%0d got %b want 0", 7 - i, data_valid); end
            end
        end
        exp_w = exp_q.pop_front();
        n_vec++; if (data_valid !== 1'b1) begin n_err++; $display("FAIL msb_valid got %b want 1", data_valid); end
        n_vec++; if (data_out !== exp_w) begin n_err++; $display("FAIL msb_data got %h want %h", data_out, exp_w); end
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL msb_busy_end got %b want 0", busy); end
        tick();
        n_vec++; if (data_valid !== 1'b0) begin n_err++; $display("FAIL msb_valid_one_cycle got %b want 0", data_valid); end
        $display("test_msb_first word %h", exp_w);
    endtask

    task automatic test_lsb_first();
        logic [7:0] seqs[3];
        bit         flips[3];
        seqs[0] = 8'b1010_0101; flips[0] = 1'b0;
        seqs[1] = 8'b1100_0000; flips[1] = 1'b0;
        seqs[2] = 8'b1110_0010; flips[2] = 1'b1;
        data_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            send_seq(seqs[k], 1'b0, 1'b1, flips[k]);
            exp_w = exp_q.pop_front();
            n_vec++; if (data_valid !== 1'b1) begin n_err++; $display("FAIL lsb_valid%0d got %b want 1", k, data_valid); end
            n_vec++; if (data_out !== exp_w) begin n_err++; $display("FAIL lsb_data%0d got %h want %h", k, data_out, exp_w); end
            tick();
            $display("test_lsb_first word %h", exp_w);
        end
    endtask

    task automatic test_gaps();
        logic [7:0] seq;
        seq = 8'h3C;
        data_ready = 1'b1;
        msb_first  = 1'b1;
        exp_q.push_back(model_word(seq, 1'b1));
        for (int i = 7; i >= 0; i--) begin
            send_bit(seq[i], 1'b0);
            if (i > 0) begin
                serial_valid = 1'b0; enable = 1'b1; serial_in = ~seq[i]; frame = 1'b1;
                tick();
                serial_valid = 1'b1; enable = 1'b0; serial_in = ~seq[i];
                tick();
                serial_valid = 1'b0; frame = 1'b0;
                n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL gap_busy bit%0d got %b want 1", 7 - i, busy); end
            end
        end
        exp_w = exp_q.pop_front();
        n_vec++; if (data_valid !== 1'b1) begin n_err++; $display("FAIL gap_valid got %b want 1", data_valid); end
        n_vec++; if (data_out !== exp_w) begin n_err++; $display("FAIL gap_data got %h want %h", data_out, exp_w); end
        tick();
        $display("test_gaps word %h", exp_w);
    endtask

    task automatic test_frame_resync();
        logic [7:0] seq;
        seq = 8'hF0;
        data_ready = 1'b1;
        msb_first  = 1'b1;
        for (int i = 0; i < 3; i++) send_bit(1'b0, 1'b0);
        exp_q.push_back(model_word(seq, 1'b1));
        for (int i = 7; i >= 0; i--) begin
            send_bit(seq[i], (i == 7));
            if (i > 0) begin
                n_vec++; if (data_valid !== 1'b0) begin n_err++; $display("FAIL frame_spurious bit%0d got %b want 0", 7 - i, data_valid); end
            end
        end
        exp_w = exp_q.pop_front();
        n_vec++; if (data_valid !== 1'b1) begin n_err++; $display("FAIL frame_valid got %b want 1", data_valid); end
        n_vec++; if (data_out !== exp_w) begin n_err++; $display("FAIL frame_data got %h want %h", data_out, exp_w); end
        n_vec++; if (overrun !== 1'b0) begin n_err++; $display("FAIL frame_overrun got %b want 0", overrun); end
        tick();
        $display("test_frame_resync word %h", exp_w);
    endtask

    task automatic test_overrun();
        data_ready = 1'b0;
        send_seq(8'h11, 1'b1, 1'b1, 1'b0);
        n_vec++; if (overrun !== 1'b0) begin n_err++; $display("FAIL ovr_early got %b want 0", overrun); end
        send_seq(8'h22, 1'b1, 1'b0, 1'b0);
        n_vec++; if (overrun !== 1'b1) begin n_err++; $display("FAIL ovr_set got %b want 1", overrun); end
        n_vec++; if (data_valid !== 1'b1) begin n_err++; $display("FAIL ovr_valid got %b want 1", data_valid); end
        exp_w = exp_q.pop_front();
        n_vec++; if (data_out !== exp_w) begin n_err++; $display("FAIL ovr_data got %h want %h", data_out, exp_w); end
        data_ready = 1'b1;
        tick();
        n_vec++; if (data_valid !== 1'b0) begin n_err++; $display("FAIL ovr_drain got %b want 0", data_valid); end
        tick();
        tick();
        n_vec++; if (overrun !== 1'b1) begin n_err++; $display("FAIL ovr_sticky got %b want 1", overrun); end
        $display("test_overrun word %h", exp_w);
    endtask

    task automatic test_drain_complete();
        logic [7:0] seq;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        n_vec++; if (overrun !== 1'b0) begin n_err++; $display("FAIL dc_reset_overrun got %b want 0", overrun); end
        data_ready = 1'b0;
        send_seq(8'h11, 1'b1, 1'b1, 1'b0);
        seq = 8'h22;
        exp_q.push_back(model_word(seq, 1'b1));
        msb_first = 1'b1;
        for (int i = 7; i >= 1; i--) send_bit(seq[i], 1'b0);
        data_ready = 1'b1;
        exp_w = exp_q.pop_front();
        n_vec++; if (data_out !== exp_w) begin n_err++; $display("FAIL dc_first_data got %h want %h", data_out, exp_w); end
        send_bit(seq[0], 1'b0);
        exp_w = exp_q.pop_front();
        n_vec++; if (data_valid !== 1'b1) begin n_err++; $display("FAIL dc_valid got %b want 1", data_valid); end
        n_vec++; if (data_out !== exp_w) begin n_err++; $display("FAIL dc_data got %h want %h", data_out, exp_w); end
        n_vec++; if (overrun !== 1'b0) begin n_err++; $display("FAIL dc_overrun got %b want 0", overrun); end
        tick();
        $display("test_drain_complete word %h", exp_w);
    endtask

    task automatic test_reset_midword();
        logic [7:0] seq;
        data_ready = 1'b0;
        send_seq(8'h5A, 1'b1, 1'b0, 1'b0);
        seq = 8'hC3;
        for (int i = 7; i >= 4; i--) send_bit(seq[i], 1'b0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        n_vec++; if (data_valid !== 1'b0) begin n_err++; $display("FAIL rmw_valid got %b want 0", data_valid); end
        n_vec++; if (data_out !== 8'h00) begin n_err++; $display("FAIL rmw_data got %h want 00", data_out); end
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL rmw_busy got %b want 0", busy); end
        n_vec++; if (overrun !== 1'b0) begin n_err++; $display("FAIL rmw_overrun got %b want 0", overrun); end
        data_ready = 1'b1;
        send_seq(8'h96, 1'b1, 1'b1, 1'b0);
        exp_w = exp_q.pop_front();
        n_vec++; if (data_valid !== 1'b1) begin n_err++; $display("FAIL rmw_clean_valid got %b want 1", data_valid); end
        n_vec++; if (data_out !== exp_w) begin n_err++; $display("FAIL rmw_clean_data got %h want %h", data_out, exp_w); end
        tick();
        $display("test_reset_midword word %h", exp_w);
    endtask

    task automatic test_back_to_back();
        logic [7:0] seq;
        bit         msb;
        data_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            seq = 8'($urandom_range(0, 255));
            msb = 1'($urandom_range(0, 1));
            send_seq(seq, msb, 1'b1, 1'b0);
            exp_w = exp_q.pop_front();
            n_vec++; if (data_valid !== 1'b1) begin n_err++; $display("FAIL b2b_valid%0d got %b want 1", k, data_valid); end
            n_vec++; if (data_out !== exp_w) begin n_err++; $display("FAIL b2b_data%0d got %h want %h", k, data_out, exp_w); end
            $display("test_back_to_back word%0d %h msb=%0d", k, exp_w, msb);
        end
        tick();
        n_vec++; if (overrun !== 1'b0) begin n_err++; $display("FAIL b2b_overrun got %b want 0", overrun); end
        n_vec++; if (exp_q.size() != 0) begin n_err++; $display("FAIL scoreboard_leftover got %0d want 0", exp_q.size()); end
    endtask

    initial begin
        reset        = 1'b1;
        enable       = 1'b0;
        serial_in    = 1'b0;
        serial_valid = 1'b0;
        frame        = 1'b0;
        msb_first    = 1'b1;
        data_ready   = 1'b0;
        test_reset();
        test_msb_first();
        test_lsb_first();
        test_gaps();
        test_frame_resync();
        test_overrun();
        test_drain_complete();
        test_reset_midword();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
